// File: rtl/tea_pkg.sv
// TEA shared definitions: round constant, key type and
// the decrypt FSM states, shared with the encryptor.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef logic [3:0][31:0] tea_key_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEC_1 = 2'd1,
    DEC_0 = 2'd2,
    DONE  = 2'd3
  } tea_state_e;

  function automatic logic [31:0] tea_sum_init(
    input int unsigned rounds
  );
    return rounds * TEA_DELTA;
  endfunction

endpackage

// File: rtl/tea_if.sv
// Byte-stream bundle of the TEA decryption core: key,
// ciphertext strobe, run request and plaintext output.
interface tea_if;
  import tea_pkg::*;

  logic       i_calculate;
  logic       i_round_key_valid;
  tea_key_t   i_round_key_data;
  logic [7:0] i_cipher_update;
  logic       i_cipher_update_valid;
  logic [7:0] o_plain_data;
  logic       o_plain_valid;

  modport master (
    output i_calculate,
    output i_round_key_valid,
    output i_round_key_data,
    output i_cipher_update,
    output i_cipher_update_valid,
    input  o_plain_data,
    input  o_plain_valid
  );

  modport slave (
    input  i_calculate,
    input  i_round_key_valid,
    input  i_round_key_data,
    input  i_cipher_update,
    input  i_cipher_update_valid,
    output o_plain_data,
    output o_plain_valid
  );

endinterface

// File: rtl/tea_round_f.sv
// TEA mixing function F(v,ka,kb,s), purely combinational;
// used for both half-rounds here and by the encryptor.
module tea_round_f (
  input  logic [31:0] v,
  input  logic [31:0] ka,
  input  logic [31:0] kb,
  input  logic [31:0] s,
  output logic [31:0] f
);

  assign f = ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);

endmodule

// File: rtl/tea_decrypt.sv
// Streaming TEA decrypt: byte load, one half-round per clock,
// held byte output. Option: TEA_DEC_CLEAR_EN wipes blk after DONE.
module tea_decrypt
  import tea_pkg::*;
#(
  parameter int ROUNDS      = 32,
  parameter int HOLD_CYCLES = 11
) (
  input logic i_clk,
  input logic i_rst,
  tea_if.slave bus
);

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [31:0] SUM_INIT =
    tea_sum_init(ROUNDS);
  localparam logic [5:0] RND_LAST = 6'(ROUNDS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  tea_state_e state_q, state_d;

  logic [63:0]   blk;
  logic [2:0]    ld_ptr;
  logic [2:0]    tx;
  logic [HW-1:0] hold;
  logic [31:0]   sum;
  logic [5:0]    rnd;

  logic [31:0] v0, v1, f1, f0;
  logic        calc, start, load;
  logic        last_rnd, hold_end, tx_end;
  tea_key_t    key;

  assign key  = bus.i_round_key_data;
  assign calc = bus.i_calculate;
  assign v0   = blk[31:0];
  assign v1   = blk[63:32];

  assign start    = calc && bus.i_round_key_valid;
  assign load     = bus.i_cipher_update_valid && !calc;
  assign last_rnd = (rnd == RND_LAST);
  assign hold_end = (hold == HOLD_LAST);
  assign tx_end   = (tx == 3'd7) && hold_end;

  tea_round_f u_f1 (
    .v  (v0),
    .ka (key[2]),
    .kb (key[3]),
    .s  (sum),
    .f  (f1)
  );

  tea_round_f u_f0 (
    .v  (v1),
    .ka (key[0]),
    .kb (key[1]),
    .s  (sum),
    .f  (f0)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // a dropped run request aborts decryption but never transmission
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = DEC_1;
      DEC_1: state_d = calc ? DEC_0 : IDLE;
      DEC_0: begin
        if (!calc)         state_d = IDLE;
        else if (last_rnd) state_d = DONE;
        else               state_d = DEC_1;
      end
      DONE:  if (tx_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blk    <= '0;
      ld_ptr <= '0;
      tx     <= '0;
      hold   <= '0;
      sum    <= '0;
      rnd    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sum <= SUM_INIT;
            rnd <= '0;
          end
        end
        DEC_1: begin
          if (calc) blk[63:32] <= v1 - f1;
        end
        DEC_0: begin
          if (calc) begin
            blk[31:0] <= v0 - f0;
            sum       <= sum - TEA_DELTA;
            rnd       <= rnd + 6'd1;
          end
        end
        DONE: begin
          if (hold_end) begin
            hold <= '0;
            tx   <= tx + 3'd1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        default: ;
      endcase
      // loads need calc low, round writes need it high: never both
      if (load) begin
        blk[{ld_ptr, 3'b000} +: 8] <= bus.i_cipher_update;
        ld_ptr <= ld_ptr + 3'd1;
      end
`ifdef TEA_DEC_CLEAR_EN
      if (state_q == DONE && tx_end) begin
        blk    <= '0;
        ld_ptr <= '0;
      end
`endif
    end
  end

  assign bus.o_plain_data  = blk[{tx, 3'b000} +: 8];
  assign bus.o_plain_valid = (state_q == DONE);

endmodule

// File: tb/tb_tea_decrypt.sv
// Directed bench for tea_decrypt: known vectors, load wrap,
// masking, abort, async reset and the TEA_DEC_CLEAR_EN option.
module tb_tea_decrypt;
  import tea_pkg::*;

  localparam int R = 32;
  localparam int H = 11;

  localparam logic [63:0] PT = 64'h01234567_89ABCDEF;
  localparam tea_key_t KEY =
    128'h00010203_04050607_08090A0B_0C0D0E0F;
  // published TEA vector: zero key, zero plaintext
  localparam logic [63:0] CT0 = 64'h94BAA940_41EA3A0A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] ct;

  always #5 clk = ~clk;

  tea_if bus ();

  tea_decrypt #(
    .ROUNDS      (R),
    .HOLD_CYCLES (H)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // independent golden encryptor
  function automatic logic [63:0] tea_enc(
    input logic [63:0] p,
    input tea_key_t    k
  );
    logic [31:0] y, z, s;
    y = p[31:0];
    z = p[63:32];
    s = '0;
    for (int i = 0; i < 32; i++) begin
      s = s + 32'h9E3779B9;
      y = y + (((z << 4) + k[0]) ^ (z + s) ^ ((z >> 5) + k[1]));
      z = z + (((y << 4) + k[2]) ^ (y + s) ^ ((y >> 5) + k[3]));
    end
    return {z, y};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    bus.i_cipher_update       = b;
    bus.i_cipher_update_valid = 1'b1;
    @(negedge clk);
    bus.i_cipher_update_valid = 1'b0;
  endtask

  task automatic load_block(input logic [63:0] c);
    for (int i = 0; i < 8; i++) strobe(c[8*i +: 8]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // start, drop calc at first DONE cycle, check all held bytes
  task automatic run_dec(
    input logic [63:0] exp,
    input string       tag
  );
    logic [7:0] eb;
    @(negedge clk);
    bus.i_calculate = 1'b1;
    repeat (2 * R) @(negedge clk);
    chk({tag, "_pre"}, 64'(bus.o_plain_valid), 64'd0);
    @(negedge clk);
    bus.i_calculate = 1'b0;
    for (int c = 0; c < 8 * H; c++) begin
      eb = exp[8*(c/H) +: 8];
      chk({tag, "_vld"}, 64'(bus.o_plain_valid), 64'd1);
      chk({tag, "_byte"}, 64'(bus.o_plain_data), 64'(eb));
      @(negedge clk);
    end
    chk({tag, "_end"}, 64'(bus.o_plain_valid), 64'd0);
  endtask

  initial begin
    bus.i_calculate           = 1'b0;
    bus.i_round_key_valid     = 1'b0;
    bus.i_round_key_data      = '0;
    bus.i_cipher_update       = '0;
    bus.i_cipher_update_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_vld", 64'(bus.o_plain_valid), 64'd0);
    chk("rst_data", 64'(bus.o_plain_data), 64'd0);
    rst = 1'b0;

    // zero key vector
    bus.i_round_key_valid = 1'b1;
    load_block(CT0);
    run_dec(64'd0, "zero");

    // round trip against the golden encryptor
    bus.i_round_key_data = KEY;
    ct = tea_enc(PT, KEY);
    load_block(ct);
    run_dec(PT, "rt");
    @(negedge clk);
`ifdef TEA_DEC_CLEAR_EN
    chk("idle_data", 64'(bus.o_plain_data), 64'h00);
`else
    chk("idle_data", 64'(bus.o_plain_data), 64'hEF);
`endif

    // load wrap: 10 strobes 00..09
    pulse_reset();
    for (int i = 0; i < 10; i++) strobe(8'(i));
    chk("wrap_b0", 64'(bus.o_plain_data), 64'h08);

    // masked strobe must not write or move the pointer
    bus.i_round_key_valid = 1'b0;
    @(negedge clk);
    bus.i_calculate           = 1'b1;
    bus.i_cipher_update       = 8'hAA;
    bus.i_cipher_update_valid = 1'b1;
    @(negedge clk);
    bus.i_cipher_update_valid = 1'b0;
    bus.i_calculate           = 1'b0;
    chk("mask_b0", 64'(bus.o_plain_data), 64'h08);
    for (int i = 1; i <= 7; i++) strobe(8'(i * 17));
    chk("mask_ptr", 64'(bus.o_plain_data), 64'h77);

    // wrapped load assembling a real ciphertext
    pulse_reset();
    bus.i_round_key_valid = 1'b1;
    strobe(8'h5A);
    strobe(8'hC3);
    for (int i = 2; i < 8; i++) strobe(ct[8*i +: 8]);
    strobe(ct[7:0]);
    strobe(ct[15:8]);
    run_dec(PT, "wrap_rt");

    // abort at cycle 20 of decryption
    pulse_reset();
    load_block(ct);
    @(negedge clk);
    bus.i_calculate = 1'b1;
    repeat (20) @(negedge clk);
    bus.i_calculate = 1'b0;
    for (int c = 0; c < 2 * R + 8 * H; c++) begin
      @(negedge clk);
      chk("abort_vld", 64'(bus.o_plain_valid), 64'd0);
    end
    load_block(ct);
    run_dec(PT, "rerun");

    // asynchronous reset in the middle of DONE
    load_block(ct);
    @(negedge clk);
    bus.i_calculate = 1'b1;
    repeat (2 * R + 1) @(negedge clk);
    bus.i_calculate = 1'b0;
    repeat (H) @(negedge clk);
    chk("pre_rst_byte", 64'(bus.o_plain_data), 64'hCD);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 64'(bus.o_plain_valid), 64'd0);
    chk("arst_data", 64'(bus.o_plain_data), 64'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
